// File: rtl/irq_ctrl_if.sv
// Bus slave interface between device_mux and irq_ctrl.
//  data_write : write data from the mux, only [7:0] carries register data
//  data_read  : registered read data, [15:8] always zero
//  addr       : byte address within the slave window
//  uds / lds  : upper / lower byte strobes, active high
//  rw         : 1 = read, 0 = write
//  ack        : access acknowledge back to the mux
interface irq_ctrl_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;

  modport master (
    output data_write, addr, uds, lds, rw,
    input  data_read, ack
  );

  modport slave (
    input  data_write, addr, uds, lds, rw,
    output data_read, ack
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller presenting the highest enabled pending level to the
// TG68 as active-low ipl_n. Seven request lines (irq[i] = level i+1) are
// synchronised, latched on rising edge or mirrored as levels, and software
// reads, masks, clears and sets them through four byte registers.
// Ports:
//  clk      system clock
//  reset_n  asynchronous active-low reset
//  bus      slave side of the device_mux bus (see irq_ctrl_if)
//  irq      asynchronous active-high requests, irq[i] = level i+1
//  ipl_n    ~(highest enabled pending level), 3'b111 = none
module irq_ctrl #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [6:0] EDGE_DEFAULT = 7'h00
) (
  input  logic          clk,
  input  logic          reset_n,
  irq_ctrl_if.slave     bus,
  input  logic [6:0]    irq,
  output logic [2:0]    ipl_n
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic        start_s;
  logic        ack_r;
  logic [6:0]  rd_r;
  logic [2:0]  ipl_r;

  logic [6:0]  sync_r [SYNC_STAGES];
  logic [6:0]  sync_s;
  logic [6:0]  prev_r;
  logic [6:0]  rise_s;

  logic [6:0]  pending_r;
  logic [6:0]  enable_r;
  logic [6:0]  edge_r;
  logic [6:0]  pending_nx_s;

  logic        strobe_s;
  logic        mapped_s;
  logic [1:0]  reg_sel_s;
  logic        wr_s;
  logic [6:0]  clr_s;
  logic [6:0]  swset_s;
  logic [2:0]  lvl_s;
  logic [6:0]  rd_mux_s;

  // Index+1 of the highest set bit, 0 when nothing is set (level 7 wins).
  function automatic logic [2:0] top_level(input logic [6:0] m);
    logic [2:0] l;
    l = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (m[i]) begin
        l = 3'(i + 1);
      end else begin
        l = l;
      end
    end
    return l;
  endfunction

  assign sync_s    = sync_r[SYNC_STAGES-1];
  assign rise_s    = sync_s & ~prev_r;
  assign strobe_s  = bus.uds | bus.lds;
  assign lvl_s     = top_level(pending_r & enable_r);

  assign bus.ack       = ack_r;
  assign bus.data_read = {9'h000, rd_r};
  assign ipl_n         = ipl_r;

  // Bus FSM next state: one access per strobe assertion.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (strobe_s && !ack_r) begin
          state_nx_s = ST_ACK;
          start_s    = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!strobe_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ACK;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Address decode, write strobes and read mux for the access being started.
  always_comb begin
    mapped_s  = (bus.addr[7:4] == 4'h0) && (bus.addr[3] == 1'b0);
    reg_sel_s = bus.addr[2:1];
    wr_s      = start_s & ~bus.rw & bus.lds & mapped_s;
    clr_s     = 7'h00;
    swset_s   = 7'h00;
    if (wr_s && (reg_sel_s == 2'd0)) begin
      clr_s = bus.data_write[6:0];
    end else begin
      clr_s = 7'h00;
    end
    if (wr_s && (reg_sel_s == 2'd3)) begin
      swset_s = bus.data_write[6:0];
    end else begin
      swset_s = 7'h00;
    end
    case (reg_sel_s)
      2'd0:    rd_mux_s = pending_r;
      2'd1:    rd_mux_s = enable_r;
      2'd2:    rd_mux_s = edge_r;
      2'd3:    rd_mux_s = {4'h0, lvl_s};
      default: rd_mux_s = 7'h00;
    endcase
  end

  // Edge bits: set (rise or SWSET) wins over W1C. Level bits mirror the synced input.
  always_comb begin
    pending_nx_s = (edge_r & ((pending_r & ~clr_s) | rise_s | swset_s))
                 | (~edge_r & sync_s);
  end

  // Input synchroniser chain and previous-sample register for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 7'h00;
      end
      prev_r <= 7'h00;
    end else begin
      sync_r[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_s;
    end
  end

  // Bus state, registers, captured read data and registered ipl_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      ack_r     <= 1'b0;
      rd_r      <= 7'h00;
      pending_r <= 7'h00;
      enable_r  <= 7'h00;
      edge_r    <= EDGE_DEFAULT;
      ipl_r     <= 3'b111;
    end else begin
      state_r   <= state_nx_s;
      ack_r     <= (state_nx_s == ST_ACK);
      pending_r <= pending_nx_s;
      ipl_r     <= ~lvl_s;
      if (wr_s && (reg_sel_s == 2'd1)) begin
        enable_r <= bus.data_write[6:0];
      end
      if (wr_s && (reg_sel_s == 2'd2)) begin
        edge_r <= bus.data_write[6:0];
      end
      if (start_s && bus.rw) begin
        rd_r <= mapped_s ? rd_mux_s : 7'h00;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a behavioural model pushes expected
// ipl_n/ack per cycle and expected read data per read access; a monitor pops
// and compares. Directed scenarios are followed by randomized traffic.
module tb_irq_ctrl;
  localparam int         SYNC = 2;
  localparam logic [6:0] EDEF = 7'h55;

  logic       clk;
  logic       reset_n;
  logic [6:0] irq;
  logic [2:0] ipl_n;

  irq_ctrl_if bus ();

  irq_ctrl #(.SYNC_STAGES(SYNC), .EDGE_DEFAULT(EDEF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq), .ipl_n(ipl_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  exp_q [$];   // {ipl_n, ack} expected after each edge
  logic [15:0] rd_q  [$];   // expected data_read per read access

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest requested level, searched from level 7 down.
  function automatic logic [2:0] model_level(input logic [6:0] m);
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) return 3'(i + 1);
    end
    return 3'd0;
  endfunction

  // Reference model: evaluated once per rising edge from the register rules.
  logic [6:0] m_hist [SYNC];
  logic [6:0] m_prev, m_pend, m_en, m_edge;
  logic       m_ack;
  logic [2:0] m_ipl;
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        for (int k = 0; k < SYNC; k++) m_hist[k] = 7'h00;
        m_prev = 7'h00; m_pend = 7'h00; m_en = 7'h00; m_edge = EDEF;
        m_ack = 1'b0; m_ipl = 3'b111;
      end else begin
        logic [6:0] s, rise, clr, set, new_en, new_edge, val;
        logic [2:0] lvl, idx;
        logic       mapped, strobe, new_ack;
        s = m_hist[SYNC-1];               // input as seen SYNC edges ago
        rise = s & ~m_prev;
        lvl = model_level(m_pend & m_en);
        strobe = bus.uds | bus.lds;
        clr = 7'h00; set = 7'h00; new_en = m_en; new_edge = m_edge;
        new_ack = m_ack;
        if (!m_ack && strobe) begin
          new_ack = 1'b1;
          idx = bus.addr[3:1];
          mapped = (bus.addr[7:4] == 4'h0) && (idx <= 3'd3);
          if (bus.rw) begin
            case (idx)
              3'd0:    val = m_pend;
              3'd1:    val = m_en;
              3'd2:    val = m_edge;
              default: val = {4'h0, lvl};
            endcase
            rd_q.push_back(mapped ? {9'h000, val} : 16'h0000);
          end else if (mapped && bus.lds) begin
            case (idx)
              3'd0:    clr = bus.data_write[6:0];
              3'd1:    new_en = bus.data_write[6:0];
              3'd2:    new_edge = bus.data_write[6:0];
              default: set = bus.data_write[6:0];
            endcase
          end
        end else if (m_ack && !strobe) begin
          new_ack = 1'b0;
        end
        for (int i = 0; i < 7; i++) begin
          if (!m_edge[i])               m_pend[i] = s[i];
          else if (set[i] || rise[i])   m_pend[i] = 1'b1;
          else if (clr[i])              m_pend[i] = 1'b0;
        end
        m_en = new_en; m_edge = new_edge; m_prev = s;
        for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = irq;
        m_ipl = ~lvl;
        m_ack = new_ack;
      end
      exp_q.push_back({m_ipl, m_ack});
    end
  end

  // Monitor: compares every cycle just after the edge, and read data on ack rise.
  initial begin
    logic       prev_ack;
    logic [3:0] e;
    prev_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("ipl_n", ipl_n, e[3:1]);
        chk("ack", bus.ack, e[0]);
      end
      if (bus.ack && !prev_ack && bus.rw) begin
        if (rd_q.size() == 0) chk("rd_q_underflow", 0, 1);
        else chk("data_read", bus.data_read, rd_q.pop_front());
      end
      prev_ack = bus.ack;
    end
  end

  // One bus access, entered at a negedge; strobes held for 'hold' acked cycles.
  task automatic access(input logic [7:0] a, input logic r, input logic [15:0] d,
                        input logic u, input logic l, input int hold);
    int t;
    bus.addr = a; bus.rw = r; bus.data_write = d; bus.uds = u; bus.lds = l;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.ack && t < 8);
    if (!bus.ack) chk("ack_rise_timeout", 0, 1);
    repeat (hold - 1) @(negedge clk);
    bus.uds = 1'b0; bus.lds = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.ack && t < 8);
    if (bus.ack) chk("ack_fall_timeout", 1, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    access(a, 1'b0, {8'h00, d}, 1'b0, 1'b1, 1);
  endtask

  task automatic rd(input logic [7:0] a);
    access(a, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
  endtask

  initial begin
    reset_n = 1'b0; irq = 7'h00;
    bus.addr = 8'h00; bus.rw = 1'b1; bus.data_write = 16'h0000;
    bus.uds = 1'b0; bus.lds = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset_ipl_n", ipl_n, 3'b111);
    rd(8'h00); rd(8'h02); rd(8'h04);

    // Single-cycle edge pulse on level 3
    wr(8'h04, 8'h7F); wr(8'h02, 8'h7F);
    irq = 7'h04; @(negedge clk); irq = 7'h00;
    repeat (6) @(negedge clk);
    chk("edge_lvl3_ipl", ipl_n, 3'b100);
    rd(8'h00);

    // Priority and masking of level 7
    wr(8'h06, 8'h01);
    irq = 7'h40; @(negedge clk); irq = 7'h00;
    repeat (6) @(negedge clk);
    chk("prio_lvl7_ipl", ipl_n, 3'b000);
    wr(8'h02, 8'h3F);
    repeat (3) @(negedge clk);
    chk("mask_lvl7_ipl", ipl_n, 3'b100);

    // W1C on the same edge as a fresh rise of level 3: set wins
    irq = 7'h04; @(negedge clk); @(negedge clk);
    wr(8'h00, 8'h04);
    irq = 7'h00;
    repeat (3) @(negedge clk);
    chk("set_wins_ipl", ipl_n, 3'b100);
    rd(8'h00);
    rd(8'h06);

    // Level mode on level 1
    wr(8'h00, 8'h7F); wr(8'h04, 8'h00); wr(8'h02, 8'h01);
    irq = 7'h01;
    repeat (5) @(negedge clk);
    chk("level_on_ipl", ipl_n, 3'b110);
    wr(8'h00, 8'h01);
    repeat (2) @(negedge clk);
    chk("level_w1c_ignored_ipl", ipl_n, 3'b110);
    irq = 7'h00;
    repeat (5) @(negedge clk);
    chk("level_off_ipl", ipl_n, 3'b111);

    // Long strobe, uds-only write, unmapped read
    access(8'h02, 1'b0, 16'h007F, 1'b1, 1'b1, 5);
    access(8'h02, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    rd(8'h02);
    rd(8'h10);
    access(8'h0E, 1'b1, 16'h0000, 1'b1, 1'b1, 2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          irq = 7'($urandom);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        1, 2: begin
          logic [7:0] a;
          logic u, l;
          a = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
          u = 1'($urandom);
          l = ($urandom_range(0, 4) != 0);
          if (!u && !l) l = 1'b1;
          access(a, (op == 2), 16'($urandom), u, l, int'($urandom_range(1, 3)));
        end
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
    end
    irq = 7'h00;
    repeat (6) @(negedge clk);

    // Reset in the middle of a held access drops the ack at once
    bus.addr = 8'h02; bus.rw = 1'b0; bus.data_write = 16'h0011;
    bus.uds = 1'b0; bus.lds = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_ack", bus.ack, 1'b0);
    chk("midreset_ipl", ipl_n, 3'b111);
    @(negedge clk);
    bus.lds = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(8'h00); rd(8'h02); rd(8'h04);

    repeat (4) @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
